// File: rtl/updi_pkg.sv
// Shared UPDI definitions: opcode constants, operation/state/size enums and
// the character framing helper used by the command sequencer.
package updi_pkg;

  localparam int unsigned MAX_FRAME_W = 12;

  localparam logic [7:0] OPC_SYNCH   = 8'h55;
  localparam logic [7:0] OPC_LDS     = 8'h00;
  localparam logic [7:0] OPC_STS     = 8'h40;
  localparam logic [7:0] OPC_ST_PTR  = 8'h68;
  localparam logic [7:0] OPC_LD_PINC = 8'h24;
  localparam logic [7:0] OPC_ST_PINC = 8'h64;
  localparam logic [7:0] OPC_REPEAT  = 8'hA0;

  // bit0 = write, bit1 = burst
  typedef enum logic [1:0] {
    OP_LDS = 2'd0,
    OP_STS = 2'd1,
    OP_LD  = 2'd2,
    OP_ST  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ASZ_BYTE  = 2'd0,
    ASZ_WORD  = 2'd1,
    ASZ_3BYTE = 2'd2
  } asz_e;

  typedef enum logic {
    DSZ_BYTE = 1'b0,
    DSZ_WORD = 1'b1
  } dsz_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_OP,
    ST_ADDR,
    ST_SYNC_REP,
    ST_REP_OP,
    ST_REP_CNT,
    ST_SYNC_PINC,
    ST_PINC_OP,
    ST_DATA,
    ST_DONE
  } state_e;

  // LDS/STS opcode: base | asz<<2 | dsz
  function automatic logic [7:0] opc_direct(input logic [7:0] base, input asz_e asz,
                                            input dsz_e dsz);
    return base | {4'h0, asz, 1'b0, dsz};
  endfunction

  // start 0, data LSB first, even parity, stop bits high; caller truncates to its width
  function automatic logic [MAX_FRAME_W-1:0] frame(input logic [7:0] b,
                                                  input int unsigned stop_bits);
    logic [MAX_FRAME_W-1:0] f;
    f      = '0;
    f[8:1] = b;
    f[9]   = ^b;
    f[10]  = 1'b1;
    f[11]  = (stop_bits > 1);
    return f;
  endfunction

endpackage

// File: rtl/updi_frame_reg.sv
// One-entry output frame register with valid/ready handshake.
//   clk_i/rstn_i : clock, async active-low reset
//   load_i/data_i: load a new frame (only when can_load_o)
//   ready_i      : downstream accepts the held frame
//   data_o/valid_o: registered frame and valid
//   can_load_o   : register empty or draining this cycle
module updi_frame_reg #(
  parameter int unsigned W = 12
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         can_load_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign can_load_o = ~valid_q | ready_i;
  assign data_o     = data_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/updi_cmd_seq.sv
// UPDI command sequencer: turns one LDS/STS/LD/ST-burst descriptor into the
// framed UPDI character stream for the PHY, pulling write data from the APP.
//   i_cmd_*            : command descriptor handshake (o_cmd_ready high only in IDLE)
//   i_data/i_valid/o_ready : APP write byte stream (o_ready = byte consumed this cycle)
//   o_data/o_valid/i_ready : framed characters to the PHY
//   o_rx_len/o_rx_start    : receive length and start pulse for load commands
//   o_busy/o_done          : command in progress / completion pulse
module updi_cmd_seq
  import updi_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned STOP_BITS  = 2,
  parameter int unsigned MAX_REP    = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [1:0]              i_cmd_op,
  input  logic [8*ADDR_BYTES-1:0] i_cmd_addr,
  input  logic                    i_cmd_word,
  input  logic [7:0]              i_cmd_rep,
  input  logic [7:0]              i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [10+STOP_BITS-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [16:0]             o_rx_len,
  output logic                    o_rx_start,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned FRAME_W = 10 + STOP_BITS;
  localparam int unsigned AW      = 8 * ADDR_BYTES;
  localparam asz_e        ASZ     = asz_e'(2'(ADDR_BYTES - 1));

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            word_q, word_d;
  logic [7:0]      rep_q, rep_d;
  logic [1:0]      addr_idx_q, addr_idx_d;
  logic [16:0]     data_cnt_q, data_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rx_start_q, rx_start_d;
  logic [16:0]     rx_len_q, rx_len_d;
  logic            cmd_ready_q, cmd_ready_d;

  logic            fr_load, fr_can_load;
  logic [7:0]      fr_byte;
  logic            ready_c;
  logic            accept, is_burst, is_write;
  logic [16:0]     n_elems;

  assign accept   = i_cmd_valid & cmd_ready_q;
  assign is_burst = op_q[1];
  assign is_write = op_q[0];
  assign n_elems  = (is_burst ? (17'(rep_q) + 17'd1) : 17'd1) << word_q;

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LDS;
      addr_q      <= '0;
      word_q      <= 1'b0;
      rep_q       <= 8'd0;
      addr_idx_q  <= 2'd0;
      data_cnt_q  <= 17'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_start_q  <= 1'b0;
      rx_len_q    <= 17'd0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      rep_q       <= rep_d;
      addr_idx_q  <= addr_idx_d;
      data_cnt_q  <= data_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rx_start_q  <= rx_start_d;
      rx_len_q    <= rx_len_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  // Next-state, frame selection and APP handshake
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    word_d      = word_q;
    rep_d       = rep_q;
    addr_idx_d  = addr_idx_q;
    data_cnt_d  = data_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rx_start_d  = 1'b0;
    rx_len_d    = rx_len_q;
    cmd_ready_d = cmd_ready_q;
    fr_load     = 1'b0;
    fr_byte     = 8'h00;
    ready_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // ready re-arms one cycle after the done pulse
        cmd_ready_d = ~accept;
        if (accept) begin
          op_d       = op_e'(i_cmd_op);
          addr_d     = i_cmd_addr;
          word_d     = i_cmd_word;
          rep_d      = (i_cmd_rep > 8'(MAX_REP)) ? 8'(MAX_REP) : i_cmd_rep;
          addr_idx_d = 2'd0;
          data_cnt_d = 17'd0;
          rx_len_d   = 17'd0;
          busy_d     = 1'b1;
          state_d    = ST_SYNC;
        end
      end
      ST_SYNC: if (fr_can_load) begin
        fr_load = 1'b1;
        fr_byte = OPC_SYNCH;
        state_d = ST_OP;
      end
      ST_OP: if (fr_can_load) begin
        fr_load = 1'b1;
        if (is_burst) fr_byte = OPC_ST_PTR | {6'd0, ASZ};
        else          fr_byte = opc_direct(is_write ? OPC_STS : OPC_LDS, ASZ, dsz_e'(word_q));
        state_d = ST_ADDR;
      end
      ST_ADDR: if (fr_can_load) begin
        fr_load    = 1'b1;
        fr_byte    = 8'(addr_q >> {addr_idx_q, 3'b000});
        addr_idx_d = addr_idx_q + 2'd1;
        if (addr_idx_q == 2'(ADDR_BYTES - 1)) begin
          addr_idx_d = 2'd0;
          if (is_burst)      state_d = (rep_q == 8'd0) ? ST_SYNC_PINC : ST_SYNC_REP;
          else if (is_write) state_d = ST_DATA;
          else               state_d = ST_DONE;
        end
      end
      ST_SYNC_REP: if (fr_can_load) begin
        fr_load = 1'b1;
        fr_byte = OPC_SYNCH;
        state_d = ST_REP_OP;
      end
      ST_REP_OP: if (fr_can_load) begin
        fr_load = 1'b1;
        fr_byte = OPC_REPEAT;
        state_d = ST_REP_CNT;
      end
      ST_REP_CNT: if (fr_can_load) begin
        fr_load = 1'b1;
        fr_byte = rep_q;
        state_d = ST_SYNC_PINC;
      end
      ST_SYNC_PINC: if (fr_can_load) begin
        fr_load = 1'b1;
        fr_byte = OPC_SYNCH;
        state_d = ST_PINC_OP;
      end
      ST_PINC_OP: if (fr_can_load) begin
        fr_load = 1'b1;
        fr_byte = (is_write ? OPC_ST_PINC : OPC_LD_PINC) | {7'd0, word_q};
        state_d = is_write ? ST_DATA : ST_DONE;
      end
      ST_DATA: begin
        ready_c = i_valid & fr_can_load;
        if (ready_c) begin
          fr_load    = 1'b1;
          fr_byte    = i_data;
          data_cnt_d = data_cnt_q + 17'd1;
          if (data_cnt_q == n_elems - 17'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // finish only once the last frame has left the output register
        if (fr_can_load) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          rx_start_d = ~is_write;
          rx_len_d   = is_write ? 17'd0 : n_elems;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  updi_frame_reg #(
    .W (FRAME_W)
  ) u_frame_reg (
    .clk_i      (i_clk),
    .rstn_i     (i_rstn),
    .load_i     (fr_load),
    .data_i     (FRAME_W'(frame(fr_byte, STOP_BITS))),
    .ready_i    (i_ready),
    .data_o     (o_data),
    .valid_o    (o_valid),
    .can_load_o (fr_can_load)
  );

  assign o_ready     = ready_c;
  assign o_cmd_ready = cmd_ready_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rx_start  = rx_start_q;
  assign o_rx_len    = rx_len_q;

endmodule

// File: tb/tb_updi_cmd_seq.sv
// Self-checking bench for updi_cmd_seq: directed and random commands, each
// compared against a byte-level model of the UPDI character sequence.
module tb_updi_cmd_seq;

  localparam int unsigned ADDR_BYTES = 2;
  localparam int unsigned STOP_BITS  = 2;
  localparam int unsigned FRAME_W    = 10 + STOP_BITS;
  localparam int unsigned AW         = 8 * ADDR_BYTES;

  logic               i_clk = 1'b0;
  logic               i_rstn = 1'b0;
  logic               i_cmd_valid = 1'b0;
  logic               o_cmd_ready;
  logic [1:0]         i_cmd_op = 2'd0;
  logic [AW-1:0]      i_cmd_addr = '0;
  logic               i_cmd_word = 1'b0;
  logic [7:0]         i_cmd_rep = 8'd0;
  logic [7:0]         i_data = 8'd0;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic [FRAME_W-1:0] o_data;
  logic               o_valid;
  logic               i_ready = 1'b1;
  logic [16:0]        o_rx_len;
  logic               o_rx_start;
  logic               o_busy;
  logic               o_done;

  always #5 i_clk = ~i_clk;

  updi_cmd_seq #(
    .ADDR_BYTES (ADDR_BYTES),
    .STOP_BITS  (STOP_BITS),
    .MAX_REP    (255)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_word  (i_cmd_word),
    .i_cmd_rep   (i_cmd_rep),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_rx_len    (o_rx_len),
    .o_rx_start  (o_rx_start),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  int total = 0;
  int bad   = 0;
  int fixed_data = -1;

  int                 exp_q[$];
  logic [7:0]         app_q[$];
  logic [FRAME_W-1:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // character on the wire: start 0, byte LSB first, even parity, stop ones
  function automatic logic [31:0] exp_frame(input int b);
    int v, p;
    v = b & 255;
    p = $countones(v) % 2;
    return 32'((((2 ** STOP_BITS) - 1) << 10) + (p << 9) + (v << 1));
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 1);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_rx_len"}, 32'(o_rx_len), 0);
  endtask

  // mode 0: random PHY ready, 1: always ready, 2: 5-cycle stall on address frame
  task automatic run_cmd(input int op, input int addr, input int word, input int rep,
                         input int mode, input int abort_at);
    int  n, cycles, budget, hold, consumed;
    bit  is_write, is_burst, seen_done, trig, prev_stall, prev_busy;
    logic [FRAME_W-1:0] prev_data;
    is_write = (op == 1) || (op == 3);
    is_burst = (op >= 2);
    n = (is_burst ? rep + 1 : 1) * (word != 0 ? 2 : 1);
    exp_q.delete(); app_q.delete(); got_q.delete();

    exp_q.push_back('h55);
    if (is_burst) exp_q.push_back('h68 + (ADDR_BYTES - 1));
    else          exp_q.push_back((is_write ? 'h40 : 'h00) + (ADDR_BYTES - 1) * 4 + word);
    for (int i = 0; i < ADDR_BYTES; i++) exp_q.push_back((addr >> (8 * i)) & 255);
    if (is_burst) begin
      if (rep != 0) begin
        exp_q.push_back('h55); exp_q.push_back('hA0); exp_q.push_back(rep);
      end
      exp_q.push_back('h55);
      exp_q.push_back((is_write ? 'h64 : 'h24) + word);
    end
    if (is_write) begin
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = (fixed_data >= 0 && i == 0) ? 8'(fixed_data) : 8'($urandom_range(0, 255));
        app_q.push_back(b);
        exp_q.push_back(int'(b));
      end
    end

    @(negedge i_clk);
    #1;
    chk("cmd_ready_before", 32'(o_cmd_ready), 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = 2'(op);
    i_cmd_addr  = AW'(addr);
    i_cmd_word  = 1'(word);
    i_cmd_rep   = 8'(rep);
    i_valid     = 1'b0;
    i_ready     = 1'b1;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
    #1;
    chk("busy_after_accept", 32'(o_busy), 1);
    chk("cmd_ready_busy", 32'(o_cmd_ready), 0);
    chk("rx_len_cleared", 32'(o_rx_len), 0);

    budget = 2000 + 10 * (n + 16);
    cycles = 0; hold = 0; consumed = 0;
    seen_done = 0; trig = 0; prev_stall = 0; prev_busy = 1; prev_data = '0;
    while (!seen_done && cycles < budget) begin
      @(negedge i_clk);
      cycles++;
      if (mode == 2 && !trig && got_q.size() == 2) begin trig = 1; hold = 5; end
      if (hold > 0) begin i_ready = 1'b0; hold--; end
      else if (mode == 0) i_ready = ($urandom_range(0, 3) != 0);
      else i_ready = 1'b1;
      i_valid = (app_q.size() > 0 || !is_write) ? ($urandom_range(0, 3) != 0) : 1'b0;
      i_data  = (app_q.size() > 0) ? app_q[0] : 8'($urandom_range(0, 255));
      // descriptors offered while busy must be ignored
      i_cmd_valid = prev_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      i_cmd_op    = 2'($urandom_range(0, 3));
      i_cmd_addr  = AW'($urandom);
      #1;
      if (prev_stall) begin
        chk("stall_valid_held", 32'(o_valid), 1);
        chk("stall_data_held", 32'(o_data), 32'(prev_data));
      end
      if (o_valid && i_ready) got_q.push_back(o_data);
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      if (!is_write && i_valid) chk("load_no_ready", 32'(o_ready), 0);
      if (o_ready) begin
        chk("ready_implies_valid", 32'(i_valid), 1);
        if (app_q.size() > 0) begin void'(app_q.pop_front()); consumed++; end
        else chk("ready_after_last", 32'(o_ready), 0);
      end
      if (abort_at > 0 && consumed >= abort_at) begin
        @(negedge i_clk);
        i_rstn = 1'b0; i_valid = 1'b0; i_cmd_valid = 1'b0;
        #1;
        check_idle_outputs("in_reset");
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        #1;
        check_idle_outputs("after_abort");
        return;
      end
      if (o_done) begin
        seen_done = 1;
        chk("done_busy_low", 32'(o_busy), 0);
        chk("done_cmd_ready_low", 32'(o_cmd_ready), 0);
        chk("done_rx_start", 32'(o_rx_start), is_write ? 0 : 1);
        chk("done_rx_len", 32'(o_rx_len), is_write ? 0 : 32'(n));
      end else if (o_rx_start) begin
        chk("rx_start_early", 32'(o_rx_start), 0);
      end
      prev_busy = o_busy;
    end
    chk("done_seen", 32'(seen_done), 1);

    @(negedge i_clk);
    i_cmd_valid = 1'b0; i_ready = 1'b1; i_valid = 1'b1;
    #1;
    chk("post_cmd_ready", 32'(o_cmd_ready), 1);
    chk("post_done_low", 32'(o_done), 0);
    chk("post_rx_start_low", 32'(o_rx_start), 0);
    chk("post_rx_len_hold", 32'(o_rx_len), is_write ? 0 : 32'(n));
    chk("post_no_ready", 32'(o_ready), 0);
    chk("post_valid_low", 32'(o_valid), 0);
    i_valid = 1'b0;

    chk("frame_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("frame%0d_op%0d", i, op), 32'(got_q[i]), exp_frame(exp_q[i]));
  endtask

  initial begin
    i_rstn = 1'b0;
    repeat (3) @(negedge i_clk);
    i_valid = 1'b1;
    #1;
    check_idle_outputs("reset");
    chk("reset_rx_start", 32'(o_rx_start), 0);
    chk("reset_data", 32'(o_data), 0);
    chk("reset_ready", 32'(o_ready), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    #1;
    check_idle_outputs("release");
    chk("release_ready", 32'(o_ready), 0);
    i_valid = 1'b0;

    fixed_data = 'hA5;
    run_cmd(1, 'h1234, 0, 0, 1, 0);
    fixed_data = -1;
    run_cmd(3, 'h4321, 0, 10, 0, 0);
    run_cmd(3, 'hBEEF, 1, 0, 0, 0);
    run_cmd(2, 'h0F0F, 1, 3, 0, 0);
    run_cmd(1, 'hCAFE, 1, 0, 2, 0);
    run_cmd(0, 'h8001, 0, 0, 0, 0);
    run_cmd(0, 'h00FF, 1, 7, 0, 0);
    run_cmd(3, 'h1111, 0, 20, 0, 5);
    run_cmd(1, 'h2222, 0, 0, 0, 0);
    run_cmd(3, 'h3333, 1, 255, 1, 0);
    run_cmd(2, 'h4444, 0, 255, 0, 0);
    for (int k = 0; k < 12; k++)
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
